// File: rtl/icu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : icu_sequencer
//  Description : Program sequencer for the 1-bit ICU core. Holds the program
//                counter and an optional return stack, addresses external
//                program memory and steers fetch from the ICU flags.
//                Optional feature macro: SEQ_STACK_EN (return stack + ERR).
//  Revision    : 1.0 - initial release
// ============================================================================
module icu_sequencer #(
  parameter int AW          = 6,
  parameter int STACK_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW+3:0] MEM_DATA,
  input  logic          JMP,
  input  logic          RTN,
  input  logic          FL0,
  input  logic          FLF,
  input  logic          RUN,
  output logic [AW-1:0] ADDR,
  output logic [3:0]    IR_OUT,
  output logic          PHASE,
  output logic          HALTED,
  output logic          ERR
);

  localparam logic [AW-1:0] c_ONE  = AW'(1);
  localparam logic [3:0]    c_NOPF = 4'b1111;

  logic          r_phase;
  logic          r_halted;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_target;

`ifdef SEQ_STACK_EN
  localparam int c_SPW = $clog2(STACK_DEPTH + 1);
  localparam int c_IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [c_SPW-1:0] c_FULL = c_SPW'(STACK_DEPTH);

  logic [AW-1:0]    r_stack [STACK_DEPTH];
  logic [c_SPW-1:0] r_sp;
  logic             r_err;
  logic [c_SPW-1:0] w_sp_dec;
  logic [c_IW-1:0]  w_push_idx;
  logic [c_IW-1:0]  w_pop_idx;
  logic             w_full;
  logic             w_empty;

  // Stack pointer decode: push writes slot sp, pop reads slot sp-1.
  always_comb begin
    w_sp_dec   = r_sp - c_SPW'(1);
    w_push_idx = r_sp[c_IW-1:0];
    w_pop_idx  = w_sp_dec[c_IW-1:0];
    w_full     = (r_sp == c_FULL);
    w_empty    = (r_sp == '0);
  end

  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  // Next sequential address and jump target from the current program word.
  always_comb begin
    w_pc_inc = r_pc + c_ONE;
    w_target = MEM_DATA[AW+3:4];
  end

  // Phase toggles every edge; all PC/halt/stack state moves only on the
  // edge that closes the execute phase.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_phase  <= 1'b0;
      r_halted <= 1'b0;
      r_pc     <= '0;
`ifdef SEQ_STACK_EN
      r_sp     <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
`endif
    end else begin
      r_phase <= ~r_phase;
      if (r_phase) begin
        if (r_halted) begin
          // While halted the ICU keeps pulsing FLF on NOPF; only RUN matters.
          if (RUN) begin
            r_halted <= 1'b0;
            r_pc     <= w_pc_inc;
          end
        end else if (FL0) begin
          r_pc <= '0;
        end else if (JMP) begin
`ifdef SEQ_STACK_EN
          // On overflow the jump is still taken but the return is lost.
          if (w_full) begin
            r_err <= 1'b1;
          end else begin
            r_stack[w_push_idx] <= w_pc_inc;
            r_sp                <= r_sp + c_SPW'(1);
          end
`endif
          r_pc <= w_target;
        end else if (RTN) begin
`ifdef SEQ_STACK_EN
          if (w_empty) begin
            r_pc  <= '0;
            r_err <= 1'b1;
          end else begin
            r_pc <= r_stack[w_pop_idx];
            r_sp <= w_sp_dec;
          end
`else
          r_pc <= w_pc_inc;
`endif
        end else if (FLF) begin
          r_halted <= 1'b1;
        end else begin
          r_pc <= w_pc_inc;
        end
      end
    end
  end

  assign ADDR   = r_pc;
  assign PHASE  = r_phase;
  assign HALTED = r_halted;
  assign IR_OUT = r_halted ? c_NOPF : MEM_DATA[3:0];

endmodule
`default_nettype wire

// File: tb/tb_icu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icu_sequencer
//  Description : Self-checking bench for icu_sequencer (AW=3, depth 2) with a
//                queue-based reference model and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icu_sequencer;

  localparam int AW    = 3;
  localparam int DEPTH = 2;
  localparam int NW    = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW+3:0] MEM_DATA;
  logic          JMP = 1'b0, RTN = 1'b0, FL0 = 1'b0, FLF = 1'b0, RUN = 1'b0;
  logic [AW-1:0] ADDR;
  logic [3:0]    IR_OUT;
  logic          PHASE, HALTED, ERR;

  logic [AW+3:0] mem [NW];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_pc;
  bit m_phase, m_halted, m_err;
  int m_stack[$];

  always #5 CLK = ~CLK;

  // Asynchronous program memory.
  always_comb MEM_DATA = mem[ADDR];

  icu_sequencer #(.AW(AW), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .MEM_DATA(MEM_DATA),
    .JMP(JMP), .RTN(RTN), .FL0(FL0), .FLF(FLF), .RUN(RUN),
    .ADDR(ADDR), .IR_OUT(IR_OUT), .PHASE(PHASE), .HALTED(HALTED), .ERR(ERR)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Execute-edge behaviour of the sequencer, from the instruction rules.
  function automatic void model_exec();
    int tgt;
    tgt = int'(mem[m_pc][AW+3:4]);
    if (m_halted) begin
      if (RUN) begin
        m_halted = 1'b0;
        m_pc = (m_pc + 1) % NW;
      end
    end else if (FL0) begin
      m_pc = 0;
    end else if (JMP) begin
`ifdef SEQ_STACK_EN
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else m_stack.push_back((m_pc + 1) % NW);
`endif
      m_pc = tgt;
    end else if (RTN) begin
`ifdef SEQ_STACK_EN
      if (m_stack.size() == 0) begin
        m_pc  = 0;
        m_err = 1'b1;
      end else begin
        m_pc = m_stack.pop_back();
      end
`else
      m_pc = (m_pc + 1) % NW;
`endif
    end else if (FLF) begin
      m_halted = 1'b1;
    end else begin
      m_pc = (m_pc + 1) % NW;
    end
  endfunction

  // Model advances on the same edges as the DUT.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pc = 0; m_phase = 1'b0; m_halted = 1'b0; m_err = 1'b0;
      m_stack.delete();
    end else begin
      if (m_phase) model_exec();
      m_phase = ~m_phase;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("addr",   int'(ADDR),   m_pc);
      chk("phase",  int'(PHASE),  int'(m_phase));
      chk("halted", int'(HALTED), int'(m_halted));
      chk("err",    int'(ERR),    int'(m_err));
      chk("ir_out", int'(IR_OUT), m_halted ? 15 : int'(mem[m_pc][3:0]));
    end
  end

  task automatic rst_on();
    RST = 1'b1;
    JMP = 0; RTN = 0; FL0 = 0; FLF = 0; RUN = 0;
    #1;
  endtask

  task automatic rst_off();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // One instruction: flags held across fetch and execute, return at negedge.
  task automatic instr(input bit j, input bit r, input bit z, input bit f, input bit u);
    JMP = j; RTN = r; FL0 = z; FLF = f; RUN = u;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    JMP = 0; RTN = 0; FL0 = 0; FLF = 0; RUN = 0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < NW; i++) mem[i] = 7'h01;
  endtask

  initial begin
    int exp_cr[5];
    fill_nop();

    // Reset state.
    rst_on(); fill_nop(); rst_off();
    chk("rst_addr",   int'(ADDR),   0);
    chk("rst_phase",  int'(PHASE),  0);
    chk("rst_halted", int'(HALTED), 0);
    chk("rst_err",    int'(ERR),    0);
    chk("rst_ir",     int'(IR_OUT), 1);

    // Linear run with wrap.
    for (int i = 0; i < 9; i++) begin
      instr(0, 0, 0, 0, 0);
      chk("lin_addr", int'(ADDR), (i + 1) % NW);
    end

    // Call/return: JMP at 2 -> 5, RTN at 5.
    rst_on(); fill_nop(); mem[2] = {3'd5, 4'h2}; rst_off();
`ifdef SEQ_STACK_EN
    exp_cr = '{1, 2, 5, 3, 4};
`else
    exp_cr = '{1, 2, 5, 6, 7};
`endif
    instr(0, 0, 0, 0, 0); chk("cr_addr0", int'(ADDR), exp_cr[0]);
    instr(0, 0, 0, 0, 0); chk("cr_addr1", int'(ADDR), exp_cr[1]);
    instr(1, 0, 0, 0, 0); chk("cr_addr2", int'(ADDR), exp_cr[2]);
    instr(0, 1, 0, 0, 0); chk("cr_addr3", int'(ADDR), exp_cr[3]);
    instr(0, 0, 0, 0, 0); chk("cr_addr4", int'(ADDR), exp_cr[4]);
    chk("cr_err", int'(ERR), 0);

    // Overflow: three nested jumps 0->1->2->5 with depth 2.
    rst_on(); fill_nop();
    mem[0] = {3'd1, 4'h1}; mem[1] = {3'd2, 4'h1}; mem[2] = {3'd5, 4'h1};
    rst_off();
    instr(1, 0, 0, 0, 0);
    instr(1, 0, 0, 0, 0);
    instr(1, 0, 0, 0, 0);
    chk("ovf_addr", int'(ADDR), 5);
`ifdef SEQ_STACK_EN
    chk("ovf_err", int'(ERR), 1);
    instr(0, 1, 0, 0, 0);
    chk("ovf_ret", int'(ADDR), 2);
`else
    chk("ovf_err", int'(ERR), 0);
    instr(0, 1, 0, 0, 0);
    chk("ovf_ret", int'(ADDR), 6);
`endif

    // Underflow: RTN on empty stack right after reset.
    rst_on(); fill_nop(); rst_off();
    instr(0, 1, 0, 0, 0);
`ifdef SEQ_STACK_EN
    chk("unf_addr", int'(ADDR), 0);
    chk("unf_err",  int'(ERR),  1);
`else
    chk("unf_addr", int'(ADDR), 1);
    chk("unf_err",  int'(ERR),  0);
`endif

    // Halt at 3, FLF pulses ignored while halted, RUN resumes at 4.
    rst_on(); fill_nop(); mem[4] = {3'd6, 4'h1}; rst_off();
    repeat (3) instr(0, 0, 0, 0, 0);
    instr(0, 0, 0, 1, 0);
    chk("halt_h",    int'(HALTED), 1);
    chk("halt_addr", int'(ADDR),   3);
    chk("halt_ir",   int'(IR_OUT), 15);
    instr(0, 0, 0, 1, 0);
    instr(0, 0, 0, 1, 0);
    chk("halt_hold", int'(ADDR), 3);
    instr(0, 0, 0, 0, 1);
    chk("run_h",    int'(HALTED), 0);
    chk("run_addr", int'(ADDR),   4);
    chk("run_ir",   int'(IR_OUT), 1);

    // FL0 beats JMP and pushes nothing: the following RTN underflows.
    instr(1, 0, 1, 0, 0);
    chk("fl0_addr", int'(ADDR), 0);
    instr(0, 1, 0, 0, 0);
`ifdef SEQ_STACK_EN
    chk("fl0_nopush_addr", int'(ADDR), 0);
    chk("fl0_nopush_err",  int'(ERR),  1);
`else
    chk("fl0_nopush_addr", int'(ADDR), 1);
    chk("fl0_nopush_err",  int'(ERR),  0);
`endif

    // Reset during execute phase with JMP high.
    rst_on(); fill_nop(); mem[0] = {3'd4, 4'h1}; mem[1] = {3'd4, 4'h1}; rst_off();
    instr(0, 1, 0, 0, 0);
    instr(1, 0, 0, 0, 0);
    JMP = 1'b1;
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("mid_addr",   int'(ADDR),   0);
    chk("mid_phase",  int'(PHASE),  0);
    chk("mid_halted", int'(HALTED), 0);
    chk("mid_err",    int'(ERR),    0);
    JMP = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    instr(0, 1, 0, 0, 0);
`ifdef SEQ_STACK_EN
    chk("mid_stack_clr_addr", int'(ADDR), 0);
    chk("mid_stack_clr_err",  int'(ERR),  1);
`else
    chk("mid_stack_clr_addr", int'(ADDR), 1);
    chk("mid_stack_clr_err",  int'(ERR),  0);
`endif

    // Randomized programs and flag traffic against the model.
    for (int r = 0; r < 4; r++) begin
      rst_on();
      for (int i = 0; i < NW; i++) mem[i] = 7'($urandom);
      rst_off();
      for (int k = 0; k < 150; k++) begin
        instr($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
